// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon permutation controller: sizes, FSM encoding,
// round-constant and 5-bit S-box helpers.
package ascon_pkg;

  localparam int STATE_W    = 320;
  localparam int WORD_W     = 64;
  localparam int MAX_ROUNDS = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  function automatic logic [7:0] rc(input logic [3:0] idx);
    return {4'hF - idx, idx};
  endfunction

  // Input/output bit 4 corresponds to word x_0 of the bit column.
  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
      5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
      5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
      5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  5'h1f: y = 5'h17;
      default: y = 5'h00;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/ascon_sbox_layer.sv
// Bit-sliced Ascon S-box layer: the 5-bit S-box applied to each of the 64 columns.
module ascon_sbox_layer
  import ascon_pkg::*;
(
  input  logic [63:0] x_0_in,
  input  logic [63:0] x_1_in,
  input  logic [63:0] x_2_in,
  input  logic [63:0] x_3_in,
  input  logic [63:0] x_4_in,
  output logic [63:0] x_0_out,
  output logic [63:0] x_1_out,
  output logic [63:0] x_2_out,
  output logic [63:0] x_3_out,
  output logic [63:0] x_4_out
);

  // Column-wise substitution
  always_comb begin
    logic [4:0] col_s;
    x_0_out = 64'd0;
    x_1_out = 64'd0;
    x_2_out = 64'd0;
    x_3_out = 64'd0;
    x_4_out = 64'd0;
    col_s   = 5'd0;
    for (int j = 0; j < WORD_W; j++) begin
      col_s = sbox({x_0_in[j], x_1_in[j], x_2_in[j], x_3_in[j], x_4_in[j]});
      x_0_out[j] = col_s[4];
      x_1_out[j] = col_s[3];
      x_2_out[j] = col_s[2];
      x_3_out[j] = col_s[1];
      x_4_out[j] = col_s[0];
    end
  end

endmodule

// File: rtl/linearDiffusionLayer.sv
// Ascon linear diffusion layer: each word XORed with two rotations of itself.
module linearDiffusionLayer (
  input  logic [63:0] x_0_in,
  input  logic [63:0] x_1_in,
  input  logic [63:0] x_2_in,
  input  logic [63:0] x_3_in,
  input  logic [63:0] x_4_in,
  output logic [63:0] x_0_out,
  output logic [63:0] x_1_out,
  output logic [63:0] x_2_out,
  output logic [63:0] x_3_out,
  output logic [63:0] x_4_out
);

  assign x_0_out = x_0_in ^ {x_0_in[18:0], x_0_in[63:19]} ^ {x_0_in[27:0], x_0_in[63:28]};
  assign x_1_out = x_1_in ^ {x_1_in[60:0], x_1_in[63:61]} ^ {x_1_in[38:0], x_1_in[63:39]};
  assign x_2_out = x_2_in ^ {x_2_in[0],    x_2_in[63:1]}  ^ {x_2_in[5:0],  x_2_in[63:6]};
  assign x_3_out = x_3_in ^ {x_3_in[9:0],  x_3_in[63:10]} ^ {x_3_in[16:0], x_3_in[63:17]};
  assign x_4_out = x_4_in ^ {x_4_in[6:0],  x_4_in[63:7]}  ^ {x_4_in[40:0], x_4_in[63:41]};

endmodule

// File: rtl/ascon_permutation_ctrl.sv
// Ascon p^a/p^b sequencer: one round (constant, S-box, linear layer) per clock,
// with start/done handshake around a 320-bit state register.
module ascon_permutation_ctrl
  import ascon_pkg::*;
#(
  parameter int MAX_ROUNDS = 12,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_rounds,
  input  logic [63:0]      x_0_in,
  input  logic [63:0]      x_1_in,
  input  logic [63:0]      x_2_in,
  input  logic [63:0]      x_3_in,
  input  logic [63:0]      x_4_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] round_idx,
  output logic [63:0]      x_0_out,
  output logic [63:0]      x_1_out,
  output logic [63:0]      x_2_out,
  output logic [63:0]      x_3_out,
  output logic [63:0]      x_4_out
);

  fsm_state_t       state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] n_s;
  logic [63:0]      x_r [5];
  logic [63:0]      c2_s;
  logic [63:0]      s_s [5];
  logic [63:0]      l_s [5];

  // Out-of-range round requests fall back to the full permutation
  always_comb begin
    if ((num_rounds != {CNT_W{1'b0}}) && (num_rounds <= CNT_W'(MAX_ROUNDS))) begin
      n_s = num_rounds;
    end else begin
      n_s = CNT_W'(MAX_ROUNDS);
    end
  end

  assign c2_s = x_r[2] ^ {56'd0, rc(round_idx[3:0])};

  ascon_sbox_layer u_sbox (
    .x_0_in (x_r[0]), .x_1_in (x_r[1]), .x_2_in (c2_s), .x_3_in (x_r[3]), .x_4_in (x_r[4]),
    .x_0_out(s_s[0]), .x_1_out(s_s[1]), .x_2_out(s_s[2]), .x_3_out(s_s[3]), .x_4_out(s_s[4])
  );

  linearDiffusionLayer u_linear (
    .x_0_in (s_s[0]), .x_1_in (s_s[1]), .x_2_in (s_s[2]), .x_3_in (s_s[3]), .x_4_in (s_s[4]),
    .x_0_out(l_s[0]), .x_1_out(l_s[1]), .x_2_out(l_s[2]), .x_3_out(l_s[3]), .x_4_out(l_s[4])
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    next_state_s = state_r;
    ready        = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_r)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          next_state_s = RUN;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_r == CNT_W'(1)) begin
          next_state_s = DONE;
        end else begin
          next_state_s = RUN;
        end
      end
      DONE: begin
        done         = 1'b1;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State words, round index and remaining-round counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) x_r[i] <= 64'd0;
      round_idx <= {CNT_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else if ((state_r == IDLE) && start) begin
      x_r[0]    <= x_0_in;
      x_r[1]    <= x_1_in;
      x_r[2]    <= x_2_in;
      x_r[3]    <= x_3_in;
      x_r[4]    <= x_4_in;
      round_idx <= CNT_W'(MAX_ROUNDS) - n_s;
      cnt_r     <= n_s;
    end else if (state_r == RUN) begin
      for (int i = 0; i < 5; i++) x_r[i] <= l_s[i];
      round_idx <= round_idx + CNT_W'(1);
      cnt_r     <= cnt_r - CNT_W'(1);
    end else begin
      round_idx <= round_idx;
      cnt_r     <= cnt_r;
    end
  end

  assign x_0_out = x_r[0];
  assign x_1_out = x_r[1];
  assign x_2_out = x_r[2];
  assign x_3_out = x_r[3];
  assign x_4_out = x_r[4];

endmodule

// File: tb/tb_ascon_permutation_ctrl.sv
// Directed bench for ascon_permutation_ctrl against a bit-sliced software model
// of the Ascon round function.
module tb_ascon_permutation_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  num_rounds = 4'd0;
  logic [63:0] xi [5];
  logic        ready, busy, done;
  logic [3:0]  round_idx;
  logic [63:0] xo [5];

  logic [63:0] m [5];
  int          n_cmp = 0;
  int          n_err = 0;

  localparam logic [63:0] IV0 = 64'h80400c0600000000;
  localparam logic [63:0] IV1 = 64'h0001020304050607;
  localparam logic [63:0] IV2 = 64'h08090a0b0c0d0e0f;
  localparam logic [63:0] IV3 = 64'h0f0e0d0c0b0a0908;
  localparam logic [63:0] IV4 = 64'h1011121314151617;

  always #5 clk = ~clk;

  ascon_permutation_ctrl #(.MAX_ROUNDS(12), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .num_rounds(num_rounds),
    .x_0_in(xi[0]), .x_1_in(xi[1]), .x_2_in(xi[2]), .x_3_in(xi[3]), .x_4_in(xi[4]),
    .ready(ready), .busy(busy), .done(done), .round_idx(round_idx),
    .x_0_out(xo[0]), .x_1_out(xo[1]), .x_2_out(xo[2]), .x_3_out(xo[3]), .x_4_out(xo[4])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] v, input int r);
    return (v >> r) | (v << (64 - r));
  endfunction

  // Reference round using the published bit-sliced Ascon formulas.
  task automatic model_round(input int idx);
    logic [63:0] a, b, c, d, e, t0, t1, t2, t3, t4;
    logic [7:0]  rcv;
    rcv = 8'(((15 - idx) << 4) | idx);
    a = m[0]; b = m[1]; c = m[2] ^ {56'd0, rcv}; d = m[3]; e = m[4];
    a ^= e; e ^= d; c ^= b;
    t0 = ~a & b; t1 = ~b & c; t2 = ~c & d; t3 = ~d & e; t4 = ~e & a;
    a ^= t1; b ^= t2; c ^= t3; d ^= t4; e ^= t0;
    b ^= a; a ^= e; d ^= c; c = ~c;
    m[0] = a ^ ror(a, 19) ^ ror(a, 28);
    m[1] = b ^ ror(b, 61) ^ ror(b, 39);
    m[2] = c ^ ror(c, 1)  ^ ror(c, 6);
    m[3] = d ^ ror(d, 10) ^ ror(d, 17);
    m[4] = e ^ ror(e, 7)  ^ ror(e, 41);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inputs(input logic [63:0] a, b, c, d, e);
    xi[0] = a; xi[1] = b; xi[2] = c; xi[3] = d; xi[4] = e;
    m[0]  = a; m[1]  = b; m[2]  = c; m[3]  = d; m[4]  = e;
  endtask

  // Runs one permutation; edges counts from the accepting edge to done.
  task automatic run_perm(input string tag, input logic [3:0] nr, input int exp_n, input bit hold);
    int edges;
    num_rounds = nr;
    start = 1'b1;
    for (int r = 12 - exp_n; r < 12; r++) model_round(r);
    step();
    if (!hold) start = 1'b0;
    check({tag, " ready_low"}, {63'd0, ready}, 64'd0);
    check({tag, " idx_first"}, {60'd0, round_idx}, 64'(12 - exp_n));
    edges = 1;
    while (done !== 1'b1 && edges < 40) begin
      check({tag, " busy"}, {63'd0, busy}, 64'd1);
      check({tag, " idx_step"}, {60'd0, round_idx}, 64'(12 - exp_n + edges - 1));
      step();
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'(exp_n + 1));
    for (int i = 0; i < 5; i++) check({tag, " result"}, xo[i], m[i]);
    step();
    check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
    check({tag, " ready_after"}, {63'd0, ready}, 64'd1);
    for (int i = 0; i < 5; i++) check({tag, " hold"}, xo[i], m[i]);
  endtask

  initial begin
    load_inputs(64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    step();
    step();
    check("rst ready", {63'd0, ready}, 64'd1);
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst idx", {60'd0, round_idx}, 64'd0);
    check("rst x0", xo[0], 64'd0);
    rst = 1'b0;
    step();

    load_inputs(64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    run_perm("p12_zero", 4'd12, 12, 1'b0);
    load_inputs(IV0, IV1, IV2, IV3, IV4);
    run_perm("p6_iv", 4'd6, 6, 1'b0);
    load_inputs(IV0, IV1, IV2, IV3, IV4);
    run_perm("p8_iv", 4'd8, 8, 1'b0);
    load_inputs(64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    run_perm("p1_zero", 4'd1, 1, 1'b0);
    load_inputs(64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    run_perm("clamp0", 4'd0, 12, 1'b0);
    load_inputs(64'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    run_perm("clamp15", 4'd15, 12, 1'b0);

    // start held high across RUN/DONE; re-accepted once back in IDLE
    load_inputs(IV0, IV1, IV2, IV3, IV4);
    run_perm("held_start", 4'd12, 12, 1'b1);
    load_inputs(IV0, IV1, IV2, IV3, IV4);
    run_perm("held_again", 4'd12, 12, 1'b0);

    // asynchronous reset in the middle of p12
    load_inputs(IV0, IV1, IV2, IV3, IV4);
    num_rounds = 4'd12;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("midrst busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    check("midrst ready", {63'd0, ready}, 64'd1);
    check("midrst busy", {63'd0, busy}, 64'd0);
    check("midrst done", {63'd0, done}, 64'd0);
    check("midrst idx", {60'd0, round_idx}, 64'd0);
    for (int i = 0; i < 5; i++) check("midrst x", xo[i], 64'd0);
    step();
    check("midrst done_hold", {63'd0, done}, 64'd0);
    rst = 1'b0;
    step();
    check("midrst no_done", {63'd0, done}, 64'd0);
    load_inputs(IV0, IV1, IV2, IV3, IV4);
    run_perm("after_rst", 4'd12, 12, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
